// File: rtl/mem_stage_unit_pkg.sv
// mem_stage_unit_pkg: shared constants for the MEM stage.
//   Mcntrljr encodings, link register index, and byte/halfword lane selects.
package mem_stage_unit_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned BYTE_W = 8;

  // Mcntrljr encodings; the reserved code 3 behaves like NO_JUMP
  localparam logic [1:0] JR_TARGET   = 2'd0;
  localparam logic [1:0] JUMP_TARGET = 2'd1;
  localparam logic [1:0] NO_JUMP     = 2'd2;

  // jal writes its link value here
  localparam logic [4:0] LINK_REG = 5'd31;

  // byte lanes, little-endian: lane 0 is bits [7:0]
  localparam logic [1:0] LANE_B0 = 2'd0;
  localparam logic [1:0] LANE_B1 = 2'd1;
  localparam logic [1:0] LANE_B2 = 2'd2;
  localparam logic [1:0] LANE_B3 = 2'd3;

  // halfword lane, selected by address bit 1
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/mem_lane_unit.sv
// mem_lane_unit: combinational sub-word handling for the data memory.
//   rd_word    : current contents of the addressed word
//   byte_sel   : address bits [1:0]
//   ld_half/ld_byte : halfword / byte load select (byte wins)
//   st_half/st_byte : halfword / byte store select (byte wins)
//   st_data    : store data from the register file
//   ld_val_c   : sign-extended load value
//   st_word_c  : word to write back, untouched lanes preserved
module mem_lane_unit
  import mem_stage_unit_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  byte_sel,
  input  logic        ld_half,
  input  logic        ld_byte,
  input  logic        st_half,
  input  logic        st_byte,
  input  logic [31:0] st_data,
  output logic [31:0] ld_val_c,
  output logic [31:0] st_word_c
);

  logic [BYTE_W-1:0] byte_v;
  logic [HALF_W-1:0] half_v;

  // load extract with sign extension
  always_comb begin
    ld_val_c = rd_word;
    byte_v   = rd_word[7:0];
    case (byte_sel)
      LANE_B0: byte_v = rd_word[7:0];
      LANE_B1: byte_v = rd_word[15:8];
      LANE_B2: byte_v = rd_word[23:16];
      LANE_B3: byte_v = rd_word[31:24];
      default: byte_v = rd_word[7:0];
    endcase
    half_v = (byte_sel[1] == HALF_HI) ? rd_word[31:16] : rd_word[15:0];
    if (ld_byte) begin
      ld_val_c = {{(WORD_W-BYTE_W){byte_v[BYTE_W-1]}}, byte_v};
    end else if (ld_half) begin
      ld_val_c = {{(WORD_W-HALF_W){half_v[HALF_W-1]}}, half_v};
    end
  end

  // store merge into the existing word
  always_comb begin
    st_word_c = st_data;
    if (st_byte) begin
      st_word_c = rd_word;
      case (byte_sel)
        LANE_B0: st_word_c[7:0]   = st_data[7:0];
        LANE_B1: st_word_c[15:8]  = st_data[7:0];
        LANE_B2: st_word_c[23:16] = st_data[7:0];
        LANE_B3: st_word_c[31:24] = st_data[7:0];
        default: st_word_c[7:0]   = st_data[7:0];
      endcase
    end else if (st_half) begin
      st_word_c = rd_word;
      if (byte_sel[1] == HALF_HI) begin
        st_word_c[31:16] = st_data[15:0];
      end else begin
        st_word_c[15:0] = st_data[15:0];
      end
    end
  end

endmodule

// File: rtl/mem_stage_unit.sv
// mem_stage_unit: MEM stage of the 5-stage MIPS pipeline.
//   Clk, Reset          : clock, synchronous active-high reset
//   M* inputs           : EX/MEM pipeline register contents
//   PCSrc/PCTarget/Flush: combinational redirect for branch/j/jal/jr
//   WB* outputs         : registered MEM/WB pipeline register
// Owns the word-organised data memory (contents survive reset).
module mem_stage_unit
  import mem_stage_unit_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mbranch,
  input  logic        Mmemread,
  input  logic        Mmemwrite,
  input  logic        Mmemtoreg,
  input  logic        Mregwrite,
  input  logic        Mcntrljalr,
  input  logic        Mcntrljald,
  input  logic [1:0]  Mcntrljr,
  input  logic        Mlh,
  input  logic        Mlb,
  input  logic        Msh,
  input  logic        Msb,
  input  logic [25:0] M250Inst,
  input  logic [31:0] MRD1,
  input  logic [31:0] MPCAddResult,
  input  logic [31:0] MAddResult,
  input  logic        MAluZero,
  input  logic [31:0] MAluResult,
  input  logic [31:0] MRD2,
  input  logic [4:0]  MRegDst,
  output logic        PCSrc,
  output logic [31:0] PCTarget,
  output logic        Flush,
  output logic        WBregwrite,
  output logic        WBmemtoreg,
  output logic [31:0] WBReadData,
  output logic [31:0] WBAluResult,
  output logic [4:0]  WBRegDst
);

  logic [31:0]          mem [MEM_WORDS];
  logic [ADDR_BITS-1:0] widx;
  logic [31:0]          rd_word;
  logic [31:0]          ld_val_c;
  logic [31:0]          st_word_c;
  logic                 unused_addr_hi;

  // upper address bits are dropped so accesses wrap modulo memory size
  assign widx           = MAluResult[ADDR_BITS+1:2];
  assign unused_addr_hi = ^MAluResult[31:ADDR_BITS+2];
  assign rd_word        = mem[widx];

  mem_lane_unit u_lane (
    .rd_word   (rd_word),
    .byte_sel  (MAluResult[1:0]),
    .ld_half   (Mlh),
    .ld_byte   (Mlb),
    .st_half   (Msh),
    .st_byte   (Msb),
    .st_data   (MRD2),
    .ld_val_c  (ld_val_c),
    .st_word_c (st_word_c)
  );

  // redirect resolution: jr, then j/jal, then taken branch
  always_comb begin
    PCSrc    = 1'b0;
    PCTarget = MPCAddResult;
    if (Mcntrljr == JR_TARGET) begin
      PCSrc    = 1'b1;
      PCTarget = MRD1;
    end else if (Mcntrljr == JUMP_TARGET) begin
      PCSrc    = 1'b1;
      PCTarget = {MPCAddResult[31:28], M250Inst, 2'b00};
    end else if (Mbranch && MAluZero) begin
      PCSrc    = 1'b1;
      PCTarget = MAddResult;
    end
    if (Reset) begin
      PCSrc = 1'b0;
    end
  end

  assign Flush = PCSrc;

  // data memory write; read above sees pre-write contents this cycle
  always_ff @(posedge Clk) begin
    if (!Reset && Mmemwrite) begin
      mem[widx] <= st_word_c;
    end
  end

  // MEM/WB pipeline register; link writes override the normal controls
  always_ff @(posedge Clk) begin
    if (Reset) begin
      WBregwrite  <= 1'b0;
      WBmemtoreg  <= 1'b0;
      WBReadData  <= 32'd0;
      WBAluResult <= 32'd0;
      WBRegDst    <= 5'd0;
    end else begin
      WBReadData <= Mmemread ? ld_val_c : 32'd0;
      if (Mcntrljald) begin
        WBregwrite  <= 1'b1;
        WBmemtoreg  <= 1'b0;
        WBAluResult <= MPCAddResult;
        WBRegDst    <= LINK_REG;
      end else if (Mcntrljalr) begin
        WBregwrite  <= 1'b1;
        WBmemtoreg  <= 1'b0;
        WBAluResult <= MPCAddResult;
        WBRegDst    <= MRegDst;
      end else begin
        WBregwrite  <= Mregwrite;
        WBmemtoreg  <= Mmemtoreg;
        WBAluResult <= MAluResult;
        WBRegDst    <= MRegDst;
      end
    end
  end

endmodule

// File: doc/mem_stage_unit.md
Name: mem_stage_unit

Overview:
Consumer end of the EX/MEM pipeline register in the 5-stage MIPS pipeline. Branches and jumps are resolved in MEM.
- Owns the word-organised data memory and performs word, halfword and byte loads and stores.
- Resolves branch, jump, jr and jal redirects.
- Registers the MEM/WB pipeline outputs that feed writeback.

Parameters:
MEM_WORDS, 1024, data memory depth in 32-bit words
ADDR_BITS, 10, word-index width (log2 MEM_WORDS)

Ports:
Clk  input  1  pipeline clock, all state updates on posedge
Reset  input  1  synchronous, active-high reset
Mbranch, Mmemread, Mmemwrite, Mmemtoreg, Mregwrite  input  1 each  MEM-stage controls
Mcntrljalr, Mcntrljald  input  1 each  link-write controls (jalr writes rd, jal writes $31)
Mcntrljr  input  2  0=jr (target MRD1), 1=j/jal (pseudo-direct target), 2=no jump, 3=reserved (treated as 2)
Mlh, Mlb, Msh, Msb  input  1 each  sub-word load/store selects (load or store selected by Mmemread/Mmemwrite)
M250Inst  input  26  instruction bits [25:0]
MRD1  input  32  rs value (jr target)
MPCAddResult  input  32  PC+4 of the MEM instruction
MAddResult  input  32  branch target
MAluZero  input  1  ALU zero flag
MAluResult  input  32  byte address / ALU result
MRD2  input  32  store data
MRegDst  input  5  destination register
PCSrc  output  1  redirect valid this cycle (combinational)
PCTarget  output  32  redirect target (combinational)
Flush  output  1  equals PCSrc; squashes IF/ID, ID/EX, EX/MEM on the next edge
WBregwrite, WBmemtoreg  output  1 each  registered
WBReadData  output  32  registered load result
WBAluResult  output  32  registered ALU result or link value
WBRegDst  output  5  registered destination

Behaviour:
- Reset, on a Clk edge with Reset=1:
  - All WB* outputs go to 0.
  - Memory writes are suppressed that cycle.
  - Memory contents are not cleared.
- Redirect priority:
  - Mcntrljr==0 gives PCTarget=MRD1.
  - Otherwise Mcntrljr==1 gives {MPCAddResult[31:28], M250Inst, 2'b00}.
  - Otherwise Mbranch & MAluZero gives MAddResult.
  - Otherwise PCSrc=0 and PCTarget=MPCAddResult.
- PCSrc and Flush are forced to 0 while Reset=1.
- Addressing: word index = MAluResult[ADDR_BITS+1:2]; upper bits are ignored, so addresses wrap modulo memory size. Little-endian: byte 0 is bits [7:0].
- Loads are combinational reads, captured into WBReadData at the edge (1-cycle latency to WB).
  - lw: the full word.
  - lh: halfword selected by addr[1], sign-extended; addr[0] is ignored.
  - lb: byte selected by addr[1:0], sign-extended.
  - Mlh and Mlb both set: lb wins.
- Stores write on posedge when Mmemwrite=1 and Reset=0.
  - sw: the full word.
  - sh: MRD2[15:0] into the lane selected by addr[1]; other lanes are preserved.
  - sb: MRD2[7:0] into lane addr[1:0]; others preserved.
  - Msh and Msb both set: sb wins.
- Mmemread and Mmemwrite both set: the write is performed and WBReadData gets the pre-write contents.
- Link writes:
  - Mcntrljald: WBRegDst=31 and WBAluResult=MPCAddResult.
  - Mcntrljalr: WBRegDst=MRegDst and WBAluResult=MPCAddResult.
  - In both cases WBregwrite=1 and WBmemtoreg=0, regardless of Mregwrite and Mmemtoreg.
- Otherwise the WB outputs are the registered copies of Mregwrite, Mmemtoreg, MAluResult and MRegDst.
- The instruction in MEM always completes, including when it causes a redirect. Squashing younger instructions is the upstream registers' job, driven by Flush.
- Reset mid-operation: a store presented in the same cycle as Reset is dropped, and the WB outputs read 0 on the following cycle.

Decomposition:
- Shared package or header holds:
  - Mcntrljr encodings: JR=0, JUMP=1, NONE=2.
  - Link register index, 31.
  - Lane-select constants.
- One natural sub-module, mem_lane_unit: combinational byte/halfword extract with sign extension and the store merge. Memory array, redirect logic and MEM/WB register stay at top level.

Test Plan:
- sw 0x11223344 at addr 0x40, then lw 0x40 -> WBReadData=0x11223344 one cycle after the load is in MEM; lb 0x43 -> 0x00000011; lb 0x40 -> 0x00000044.
- sb 0xAA at 0x41 over that word, then lw 0x40 -> 0x1122AA44; lh 0x40 -> 0xFFFFAA44; lh 0x42 -> 0x00001122.
- Branch: Mbranch=1, MAluZero=1, MAddResult=0x100 -> PCSrc=1, Flush=1, PCTarget=0x100 in the same cycle. With MAluZero=0 -> PCSrc=0.
- jal with MPCAddResult=0x80000010, M250Inst=0x0000040, Mcntrljr=1, Mcntrljald=1 -> PCTarget=0x80000100; next cycle WBRegDst=31, WBAluResult=0x80000010, WBregwrite=1. jr with Mcntrljr=0, MRD1=0x200 -> PCTarget=0x200 even when Mbranch & MAluZero are set.
- Reset asserted for one cycle together with sw 0xDEADBEEF at 0x80 -> all WB* outputs 0 and PCSrc=0; a later lw 0x80 returns the prior contents.
- Address wrap: sw at (MEM_WORDS*4)+0x8 then lw 0x8 -> same data.
